// File: rtl/bp_me_nonsynth_cfg_io_responder.sv
// Nonsynth MMIO config responder: dword register file behind an in-order, fixed-latency response FIFO.
// Optional address checking is enabled by defining BP_ME_CFG_IO_RESPONDER_ADDR_CHECK_EN.
package bp_me_nonsynth_cfg_io_responder_pkg;

  typedef enum int unsigned {e_bp_default_cfg = 0} bp_params_e;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned dword_width_gp     = 64;
  localparam int unsigned cce_block_width_gp = 512;
  localparam int unsigned lce_id_width_gp    = 4;
  localparam int unsigned lce_max_assoc_gp   = 8;

  typedef struct packed {
    int unsigned paddr_width;
    int unsigned dword_width;
    int unsigned cce_block_width;
    int unsigned lce_id_width;
    int unsigned lce_max_assoc;
  } bp_proc_param_s;

  function automatic bp_proc_param_s bp_get_cfg(input bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      default: p = '{paddr_width: paddr_width_gp, dword_width: dword_width_gp,
                     cce_block_width: cce_block_width_gp, lce_id_width: lce_id_width_gp,
                     lce_max_assoc: lce_max_assoc_gp};
    endcase
    return p;
  endfunction

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]           lce_id;
    logic [$clog2(lce_max_assoc_gp)-1:0]  way_id;
  } bp_cce_mem_msg_payload_s;

  typedef struct packed {
    bp_cce_mem_msg_payload_s     payload;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    bp_cce_mem_cmd_type_e        msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s         header;
    logic [cce_block_width_gp-1:0]  data;
  } bp_cce_mem_msg_s;

endpackage

module bp_me_nonsynth_cfg_io_responder
  import bp_me_nonsynth_cfg_io_responder_pkg::*;
  #(parameter bp_params_e  bp_params_p = e_bp_default_cfg
   ,parameter int unsigned reg_els_p   = 64
   ,parameter int unsigned fifo_els_p  = 4
   ,parameter int unsigned latency_p   = 2
   ,localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s)
   ,localparam int unsigned outstanding_width_lp = $clog2(fifo_els_p+1)
   )
  (input  logic                            clk_i
  ,input  logic                            reset_i
  ,input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
  ,input  logic                            io_cmd_v_i
  ,output logic                            io_cmd_yumi_o
  ,output logic [cce_mem_msg_width_lp-1:0] io_resp_o
  ,output logic                            io_resp_v_o
  ,input  logic                            io_resp_ready_i
  ,output logic [outstanding_width_lp-1:0] outstanding_o
  ,output logic                            err_o
  );

  localparam bp_proc_param_s cfg_lp       = bp_get_cfg(bp_params_p);
  localparam int unsigned dword_width_p     = cfg_lp.dword_width;
  localparam int unsigned cce_block_width_p = cfg_lp.cce_block_width;
  localparam int unsigned lg_reg_els_lp     = $clog2(reg_els_p);
  localparam int unsigned lg_fifo_els_lp    = $clog2(fifo_els_p);

  bp_cce_mem_msg_s cmd, resp_n;
  assign cmd = bp_cce_mem_msg_s'(io_cmd_i);

  logic [dword_width_p-1:0]  regs_r [reg_els_p];
  bp_cce_mem_msg_s           fifo_msg_r [fifo_els_p];
  logic [7:0]                fifo_stamp_r [fifo_els_p];
  logic [fifo_els_p-1:0]     fifo_ripe_r;
  logic [lg_fifo_els_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [outstanding_width_lp-1:0] cnt_r;
  logic [7:0]                cycle_cnt_r;

  logic full, empty, yumi, deq, is_wr, is_rd, addr_err, reg_we;
  logic [lg_reg_els_lp-1:0] idx;
  logic [7:0] head_age;
  logic unused_data;

  assign unused_data = ^cmd.data[cce_block_width_p-1:dword_width_p];

  assign full  = (cnt_r == outstanding_width_lp'(fifo_els_p));
  assign empty = (cnt_r == '0);
  assign yumi  = io_cmd_v_i & ~full & ~reset_i;
  assign idx   = cmd.header.addr[3 +: lg_reg_els_lp];
  assign is_wr = (cmd.header.msg_type == e_cce_mem_wr) | (cmd.header.msg_type == e_cce_mem_uc_wr);
  assign is_rd = (cmd.header.msg_type == e_cce_mem_rd) | (cmd.header.msg_type == e_cce_mem_uc_rd);

`ifdef BP_ME_CFG_IO_RESPONDER_ADDR_CHECK_EN
  assign addr_err = (|cmd.header.addr[paddr_width_gp-1:3+lg_reg_els_lp]) | (|cmd.header.addr[2:0]);
  assign err_o    = yumi & addr_err;
`else
  assign addr_err = 1'b0;
  assign err_o    = 1'b0;
`endif

  assign reg_we = yumi & is_wr & ~addr_err;

  // Response built at accept time so reads see only earlier-cycle writes
  always_comb begin
    resp_n        = '0;
    resp_n.header = cmd.header;
    if (is_rd)
      resp_n.data[dword_width_p-1:0] = addr_err ? '1 : regs_r[idx];
  end

  // Ripe bit keeps valid asserted even if the 8-bit age later wraps while stalled
  assign head_age      = 8'(cycle_cnt_r - fifo_stamp_r[rd_ptr_r]);
  assign io_resp_v_o   = ~empty & (fifo_ripe_r[rd_ptr_r] | (head_age >= 8'(latency_p)));
  assign io_resp_o     = fifo_msg_r[rd_ptr_r];
  assign deq           = io_resp_v_o & io_resp_ready_i;
  assign io_cmd_yumi_o = yumi;
  assign outstanding_o = cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_cnt_r <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      fifo_ripe_r <= '0;
      for (int i = 0; i < reg_els_p; i++) regs_r[i] <= '0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 8'd1;
      for (int i = 0; i < fifo_els_p; i++)
        if (8'(cycle_cnt_r - fifo_stamp_r[i]) >= 8'(latency_p)) fifo_ripe_r[i] <= 1'b1;
      if (yumi) begin
        fifo_ripe_r[wr_ptr_r] <= 1'b0;
        wr_ptr_r              <= wr_ptr_r + lg_fifo_els_lp'(1);
      end
      if (deq) rd_ptr_r <= rd_ptr_r + lg_fifo_els_lp'(1);
      if (yumi & ~deq)      cnt_r <= cnt_r + outstanding_width_lp'(1);
      else if (~yumi & deq) cnt_r <= cnt_r - outstanding_width_lp'(1);
      if (reg_we) regs_r[idx] <= cmd.data[dword_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (yumi) begin
      fifo_msg_r[wr_ptr_r]   <= resp_n;
      fifo_stamp_r[wr_ptr_r] <= cycle_cnt_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(deq && empty));
      assert (cnt_r <= outstanding_width_lp'(fifo_els_p));
    end
  end

endmodule

// File: tb/tb_bp_me_nonsynth_cfg_io_responder.sv
// Randomized bench for bp_me_nonsynth_cfg_io_responder against a queue-based reference model.
module tb_bp_me_nonsynth_cfg_io_responder;
  import bp_me_nonsynth_cfg_io_responder_pkg::*;

  localparam int unsigned MW   = $bits(bp_cce_mem_msg_s);
  localparam int unsigned REGS = 64;
  localparam int unsigned DEP  = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned OW   = $clog2(DEP+1);

  logic clk_i = 1'b0;
  logic reset_i;
  bp_cce_mem_msg_s io_cmd_i;
  logic io_cmd_v_i, io_cmd_yumi_o, io_resp_v_o, io_resp_ready_i, err_o;
  logic [MW-1:0] io_resp_o;
  logic [OW-1:0] outstanding_o;

  bp_me_nonsynth_cfg_io_responder #(
    .bp_params_p(e_bp_default_cfg), .reg_els_p(REGS), .fifo_els_p(DEP), .latency_p(LAT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i),
    .io_cmd_yumi_o(io_cmd_yumi_o), .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o),
    .io_resp_ready_i(io_resp_ready_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bp_cce_mem_msg_s msg;
    int              t;
  } exp_s;

  exp_s        q[$];
  logic [63:0] mregs [REGS];
  int          cyc;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [paddr_width_gp-1:0] a);
`ifdef BP_ME_CFG_IO_RESPONDER_ADDR_CHECK_EN
    return ((a >> (3 + $clog2(REGS))) != 0) || (a[2:0] != 3'd0);
`else
    return (a[0] & 1'b0);
`endif
  endfunction

  function automatic bp_cce_mem_msg_s mk(input logic [3:0] typ, input logic [paddr_width_gp-1:0] a,
                                         input logic [63:0] d);
    bp_cce_mem_msg_s m;
    for (int i = 0; i < cce_block_width_gp/32; i++) m.data[32*i +: 32] = $urandom;
    m.data[63:0]           = d;
    m.header.msg_type      = bp_cce_mem_cmd_type_e'(typ);
    m.header.addr          = a;
    m.header.size          = 3'($urandom_range(0, 7));
    m.header.payload       = $bits(bp_cce_mem_msg_payload_s)'($urandom);
    return m;
  endfunction

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive, check outputs mid-cycle against the model, then advance the model
  task automatic step(input logic v, input bp_cce_mem_msg_s m, input logic r, input logic rst,
                      output logic acc);
    logic exp_yumi, exp_v, err;
    bp_cce_mem_msg_s e;
    int idx;
    reset_i = rst; io_cmd_v_i = v; io_cmd_i = m; io_resp_ready_i = r;
    @(negedge clk_i);
    exp_yumi = v && !rst && (q.size() < DEP);
    exp_v    = (q.size() > 0) && ((cyc - q[0].t) >= LAT);
    err      = is_err(m.header.addr);
    check("yumi", MW'(io_cmd_yumi_o), MW'(exp_yumi));
    if (!rst) begin
      check("resp_v", MW'(io_resp_v_o), MW'(exp_v));
      check("outstanding", MW'(outstanding_o), MW'(q.size()));
      check("err", MW'(err_o), MW'(exp_yumi && err));
      if (exp_v) check("resp_msg", io_resp_o, q[0].msg);
    end
    acc = exp_yumi;
    if (rst) begin
      q.delete();
      for (int i = 0; i < REGS; i++) mregs[i] = '0;
    end else begin
      if (exp_v && r) void'(q.pop_front());
      if (acc) begin
        idx = int'((m.header.addr >> 3) % REGS);
        e = '0;
        e.header = m.header;
        if (m.header.msg_type inside {e_cce_mem_rd, e_cce_mem_uc_rd})
          e.data[63:0] = err ? 64'hFFFF_FFFF_FFFF_FFFF : mregs[idx];
        if (m.header.msg_type inside {e_cce_mem_wr, e_cce_mem_uc_wr} && !err)
          mregs[idx] = m.data[63:0];
        q.push_back('{msg: e, t: cyc});
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic send(input bp_cce_mem_msg_s m, input int rmode);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    while (!acc && n < 64) begin
      step(1'b1, m, rdy(rmode), 1'b0, acc);
      n++;
    end
    if (!acc) check("send_timeout", MW'(0), MW'(1));
  endtask

  task automatic idle(input int n, input int rmode);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy(rmode), 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      idle(1, 1);
      n++;
    end
    check("drain_outstanding", MW'(outstanding_o), MW'(0));
  endtask

  function automatic logic [paddr_width_gp-1:0] rand_addr();
`ifdef BP_ME_CFG_IO_RESPONDER_ADDR_CHECK_EN
    if ($urandom_range(0, 3) != 0) return paddr_width_gp'($urandom_range(0, REGS-1) * 8);
`endif
    return {8'($urandom), $urandom};
  endfunction

  initial begin
    logic acc;
    logic accs [6];
    bp_cce_mem_msg_s wm [6];
    checks = 0; errors = 0; cyc = 0;
    reset_i = 1'b1; io_cmd_v_i = 1'b0; io_cmd_i = '0; io_resp_ready_i = 1'b0;
    for (int i = 0; i < REGS; i++) mregs[i] = '0;

    // Reset, including a valid command presented during reset
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b1, mk(4'd1, 40'h8, 64'h1), 1'b1, 1'b1, acc);
    idle(2, 1);

    // Write then read 0x10
    send(mk(4'd3, 40'h10, 64'hDEAD_BEEF), 1);
    send(mk(4'd2, 40'h10, 64'h0), 1);
    drain();

    // Six back-to-back writes with the sink stalled
    for (int i = 0; i < 6; i++) wm[i] = mk(4'd1, 40'(8*(i+1)), 64'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, wm[i], 1'b0, 1'b0, accs[i]);
    check("full_outstanding", MW'(outstanding_o), MW'(DEP));
    for (int i = 0; i < 6; i++) if (!accs[i]) send(wm[i], 1);
    drain();

    // 300 continuous random commands with the sink always ready
    for (int i = 0; i < 300; i++)
      send(mk(4'($urandom_range(0, 7)), rand_addr(), {$urandom, $urandom}), 1);
    drain();

    // Reset with three commands outstanding
    send(mk(4'd1, 40'h28, 64'h5555_AAAA_1234_5678), 1);
    drain();
    for (int i = 0; i < 3; i++) send(mk(4'd0, 40'h28, 64'h0), 0);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    idle(1, 1);
    send(mk(4'd0, 40'h28, 64'h0), 1);
    drain();

    // Fill registers with index*3, read back under random back-pressure
    for (int i = 0; i < REGS; i++) begin
      send(mk(4'd1, 40'(8*i), 64'(3*i)), 2);
      if ($urandom_range(0, 3) == 0) idle(1, 2);
    end
    for (int i = 0; i < REGS; i++) begin
      send(mk(4'd2, 40'(8*i), 64'h0), 2);
      if ($urandom_range(0, 3) == 0) idle(1, 2);
    end
    drain();

    // Out-of-range address: error path when checking is enabled, aliasing otherwise
    send(mk(4'd1, 40'h0, 64'h1234), 1);
    send(mk(4'd3, 40'h1_0000, 64'hFEED_F00D), 1);
    send(mk(4'd0, 40'h0, 64'h0), 1);
    send(mk(4'd2, 40'h1_0000, 64'h0), 1);
    send(mk(4'd0, 40'h3, 64'h0), 1);
    drain();

    // Random mix under random back-pressure
    for (int i = 0; i < 150; i++) begin
      send(mk(4'($urandom_range(0, 7)), rand_addr(), {$urandom, $urandom}), 2);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 2);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
